rr_grant_ctrl: RTL and testbench



---
 rtl/arb_pkg.sv | 17 +
 rtl/onehot_dec.sv | 19 +
 rtl/rr_pick.sv | 33 +++
 rtl/rr_grant_ctrl.sv | 127 ++++++++++++
 tb/tb_rr_grant_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encoding and sizing helpers for the round-robin grant controller
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    // Index width needed to address n requesters; never narrower than one bit.
    function automatic int idx_width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_IDX_WIDTH = idx_width_of(DEF_NUM_REQ);

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - binary-to-one-hot decoder with enable
module onehot_dec #(
    parameter int IN_W  = 2,
    parameter int OUT_W = 4
) (
    input  logic             en,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out
);

    // Exactly one output bit per input code; all zero when disabled.
    always_comb begin
        out = '0;
        for (int i = 0; i < OUT_W; i++) begin
            out[i] = en && (int'(in) == i);
        end
    end

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker (double-width mask-and-scan)
module rr_pick #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic                 found,
    output logic [IDX_WIDTH-1:0] idx
);

    logic [NUM_REQ-1:0]   masked;
    logic [2*NUM_REQ-1:0] dbl;

    // Lower half holds requests at or above ptr, upper half the full vector for the wrap;
    // the lowest set bit of the concatenation is the round-robin winner.
    always_comb begin
        masked = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            masked[i] = req[i] && (i >= int'(ptr));
        end
        dbl   = {req, masked};
        found = 1'b0;
        idx   = '0;
        for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
            if (dbl[i]) begin
                found = 1'b1;
                idx   = (i >= NUM_REQ) ? IDX_WIDTH'(i - NUM_REQ) : IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/rr_grant_ctrl.sv
// rtl/rr_grant_ctrl.sv - round-robin arbiter holding one grant until done, abandon or hold timeout
module rr_grant_ctrl
    import arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2,
    parameter int MAX_HOLD  = 15,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 done,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [IDX_WIDTH-1:0] gnt_idx,
    output logic                 gnt_valid,
    output logic                 timeout
);

    arb_state_t           state, state_n;
    logic [IDX_WIDTH-1:0] ptr, ptr_n;
    logic [IDX_WIDTH-1:0] idx, idx_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic                 timeout_q, timeout_n;

    logic [IDX_WIDTH-1:0] ptr_inc;
    logic [IDX_WIDTH-1:0] pick_ptr;
    logic                 pick_found;
    logic [IDX_WIDTH-1:0] pick_idx;
    logic                 owner_req;
    logic                 hold_hit;
    logic                 release_now;

    // Pointer one past the current owner, wrapping at NUM_REQ-1 so non-power-of-2 counts work.
    always_comb begin
        ptr_inc = (idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    end

    // Release conditions; in a release cycle the re-pick already scans from the updated pointer
    // so the outgoing owner is last in line.
    always_comb begin
        owner_req   = req[idx];
        hold_hit    = (MAX_HOLD != 0) && (cnt == CNT_WIDTH'(MAX_HOLD));
        release_now = (state == OWNED) && (done || !owner_req || hold_hit);
        pick_ptr    = (state == OWNED) ? ptr_inc : ptr;
    end

    rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state and next-grant decision.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        idx_n     = idx;
        cnt_n     = cnt;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_n = OWNED;
                    idx_n   = pick_idx;
                    cnt_n   = '0;
                end
            end
            OWNED: begin
                if (release_now) begin
                    ptr_n     = ptr_inc;
                    // A completing or departing owner is never reported as forced out.
                    timeout_n = hold_hit && !done && owner_req;
                    cnt_n     = '0;
                    if (pick_found) begin
                        idx_n = pick_idx;
                    end else begin
                        state_n = IDLE;
                        idx_n   = '0;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
                cnt_n   = '0;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            idx       <= '0;
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            idx       <= idx_n;
            cnt       <= cnt_n;
            timeout_q <= timeout_n;
        end
    end

    assign gnt_valid = (state == OWNED);
    assign gnt_idx   = idx;
    assign timeout   = timeout_q;

    onehot_dec #(
        .IN_W  (IDX_WIDTH),
        .OUT_W (NUM_REQ)
    ) u_dec (
        .en  (gnt_valid),
        .in  (idx),
        .out (gnt)
    );

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// tb/tb_rr_grant_ctrl.sv - directed self-checking bench for rr_grant_ctrl
module tb_rr_grant_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    rr_grant_ctrl #(
        .NUM_REQ   (4),
        .IDX_WIDTH (2),
        .MAX_HOLD  (15),
        .CNT_WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] exp_gnt, input logic exp_valid,
                             input logic [1:0] exp_idx, input logic exp_to);
        chk({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
        chk({tag, ".valid"}, 32'(gnt_valid), 32'(exp_valid));
        chk({tag, ".idx"}, 32'(gnt_idx), 32'(exp_idx));
        chk({tag, ".timeout"}, 32'(timeout), 32'(exp_to));
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        step();
        step();
        chk_grant("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
        chk("reset.ptr", 32'(dut.ptr), 32'd0);
        rst = 1'b0;

        // Idle with no requests.
        for (int c = 0; c < 5; c++) begin
            step();
            chk_grant("idle", 4'b0000, 1'b0, 2'd0, 1'b0);
        end

        // req=0101, done at cycle 3: owner 0 for cycles 1..3, then owner 2 without a gap.
        req = 4'b0101;
        for (int c = 1; c <= 3; c++) begin
            step();
            chk_grant("two_req.first", 4'b0001, 1'b1, 2'd0, 1'b0);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        chk_grant("two_req.second", 4'b0100, 1'b1, 2'd2, 1'b0);
        chk("two_req.ptr", 32'(dut.ptr), 32'd1);
        step();
        chk_grant("two_req.hold", 4'b0100, 1'b1, 2'd2, 1'b0);
        req = 4'b0000;
        step();
        chk_grant("two_req.idle", 4'b0000, 1'b0, 2'd0, 1'b0);
        chk("two_req.ptr_after", 32'(dut.ptr), 32'd3);

        // done while idle is ignored.
        done = 1'b1;
        step();
        done = 1'b0;
        chk_grant("idle_done", 4'b0000, 1'b0, 2'd0, 1'b0);

        // All four requesting, done in every second owned cycle: order 0,1,2,3,0.
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            step();
            done = 1'b0;
            chk_grant($sformatf("rr%0d.a", g), 4'(1 << (g % 4)), 1'b1, 2'(g % 4), 1'b0);
            step();
            chk_grant($sformatf("rr%0d.b", g), 4'(1 << (g % 4)), 1'b1, 2'(g % 4), 1'b0);
            done = 1'b1;
        end
        req  = 4'b0000;
        step();
        done = 1'b0;
        chk_grant("rr.idle", 4'b0000, 1'b0, 2'd0, 1'b0);

        // Hold timeout: requester 3 alone, never done; 16 owned cycles then a forced release.
        do_reset();
        req = 4'b1000;
        for (int c = 1; c <= 16; c++) begin
            step();
            chk_grant($sformatf("hold.c%0d", c), 4'b1000, 1'b1, 2'd3, 1'b0);
        end
        step();
        chk_grant("hold.timeout", 4'b1000, 1'b1, 2'd3, 1'b1);
        chk("hold.ptr", 32'(dut.ptr), 32'd0);
        step();
        chk_grant("hold.after", 4'b1000, 1'b1, 2'd3, 1'b0);

        // Requester 2 owns, others ignored, drops req at cycle 5 -> requester 0 at cycle 6.
        do_reset();
        req = 4'b0100;
        step();
        chk_grant("aband.c1", 4'b0100, 1'b1, 2'd2, 1'b0);
        req = 4'b0101;
        for (int c = 2; c <= 5; c++) begin
            step();
            chk_grant($sformatf("aband.c%0d", c), 4'b0100, 1'b1, 2'd2, 1'b0);
        end
        req = 4'b0001;
        step();
        chk_grant("aband.c6", 4'b0001, 1'b1, 2'd0, 1'b0);
        chk("aband.ptr", 32'(dut.ptr), 32'd3);

        // Reset in the middle of a grant with req=0010 held.
        do_reset();
        req = 4'b0010;
        step();
        chk_grant("mid.grant", 4'b0010, 1'b1, 2'd1, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_grant("mid.reset", 4'b0000, 1'b0, 2'd0, 1'b0);
        chk("mid.ptr", 32'(dut.ptr), 32'd0);
        step();
        chk_grant("mid.regrant", 4'b0010, 1'b1, 2'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
